cell_alu_pipe: RTL and testbench
================================

CELL_ALU_PIPE -- requirements
Module: cell_alu_pipe

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 8, meaning bits per color channel.
REQ-002 SHALL have parameter CHANNEL_NUM, default 3, meaning channels per pixel.
REQ-003 SHALL have parameter CELL_N, default 3, meaning cell edge length in pixels; odd, at least 3.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  input beat present.
REQ-008 SHALL have port in_ready  output  1  block accepts an input beat this cycle.
REQ-009 SHALL have port opcode  input  4  operation, encoded as opcodes_t.
REQ-010 SHALL have port cell_a  input  CELL_DEPTH  operand cell A, pixel-matrix order.
REQ-011 SHALL have port cell_b  input  CELL_DEPTH  operand cell B; only its center pixel is used.
REQ-012 SHALL have port user_in  input  CHANNEL_WIDTH  immediate operand.
REQ-013 SHALL have port out_valid  output  1  result beat present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the result beat.
REQ-015 SHALL have port out_pixel  output  PIXEL_DEPTH  result pixel.
REQ-016 SHALL have port out_err  output  1  result came from an illegal opcode.

Function
REQ-017 SHALL transfer an input beat when in_valid and in_ready are both high on a clk edge, and an output beat when out_valid and out_ready are both high.
REQ-018 SHALL use a two-stage pipeline:
- S1 registers opcode, cell_a, the cell_b center pixel and user_in.
- S2 registers the computed result.
REQ-019 SHALL produce out_valid two cycles after an accepted beat when there is no stall.
REQ-020 SHALL sustain one beat per cycle while out_ready is high.
REQ-021 SHALL advance each stage only when the next stage is empty or transferring.
- in_ready = !s1_valid || s1_advance, combinational.
- in_ready SHALL NOT depend on in_valid.
REQ-022 SHALL hold out_pixel and out_err stable while out_valid is high and out_ready is low; no beat is lost or duplicated.
REQ-023 SHALL compute per channel c on the center pixel (index (CELL_N*CELL_N-1)/2), with A = center of cell_a and B = center of cell_b:
- ADD: A+B. ADDI: A+user_in.
- SUB: A-B. SUBI: A-user_in.
- MULT: A*B. MULTI: A*user_in.
- DIV2: A>>1. INV: ~A.
- AND, OR, NOR: bitwise on A and B.
REQ-024 SHALL compute AVG per channel as floor(sum over all CELL_N*CELL_N pixels of cell_a / (CELL_N*CELL_N)).
- The accumulator SHALL be CHANNEL_WIDTH+$clog2(CELL_N*CELL_N) bits wide, so no overflow is possible.
- The division SHALL be exact floor division, not a shift approximation.
REQ-025 SHALL, for opcode values 12-15, output out_pixel = 0 with out_err = 1 on that beat only.
REQ-026 SHALL keep channel 0 at bits [CHANNEL_WIDTH-1:0], ascending, on all pixel buses.

Reset
REQ-027 SHALL, while rst_n is low, clear all stage valid flags immediately.
- out_valid = 0, out_pixel = 0, out_err = 0.
- in_ready = 1.
REQ-028 SHALL discard beats in flight when reset asserts mid-operation, and SHALL NOT emit them after release.
REQ-029 SHALL accept input on the first clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL define behaviour with CELL_ALU_SATURATE_EN defined:
- ADD, ADDI, MULT and MULTI clamp at 2^CHANNEL_WIDTH-1.
- SUB and SUBI clamp at 0.
REQ-031 SHALL define behaviour without CELL_ALU_SATURATE_EN: those operations wrap modulo 2^CHANNEL_WIDTH, keeping the low bits.
REQ-032 SHALL NOT change AVG, DIV2, INV or the logic operations under CELL_ALU_SATURATE_EN.

Structure
REQ-033 SHALL take the following from the shared package CellProcessingPkg, derived from the module parameters:
- opcodes_t, colorChannel_t, pixel_t, cell_t.
- PIXEL_DEPTH, CELL_DEPTH, the center index constant.
REQ-034 SHALL place per-channel arithmetic in one sub-module, cell_channel_alu, instantiated CHANNEL_NUM times inside S2.
- It covers the opcode mux and the saturation option.
- AVG summation SHALL stay in cell_alu_pipe.

Verification
REQ-035 SHALL cover ADDI with center channels {0xF0,0x10,0x80} and user_in 0x20 -> {0x10,0x30,0xA0} without the macro, and {0xFF,0x30,0xA0} with CELL_ALU_SATURATE_EN.
REQ-036 SHALL cover SUB with A center {0x05,0x50,0x00} and B center {0x10,0x10,0x01} -> {0xF5,0x40,0xFF} without the macro, and {0x00,0x40,0x00} with it.
REQ-037 SHALL cover AVG with 9 pixels all channels 0xFF -> {0xFF,0xFF,0xFF}, and with channel 0 values 0..8 -> channel 0 = 0x04.
REQ-038 SHALL cover back-to-back beats ADD, INV, DIV2 on 3 consecutive cycles with out_ready = 1 -> results on cycles 2, 3, 4 in order.
REQ-039 SHALL cover out_ready low for 5 cycles with a continuous input stream:
- in_ready drops once both stages are full.
- out_pixel stays constant; zero beats are lost after release.
REQ-040 SHALL cover opcode 14 -> out_err = 1 and out_pixel = 0, then an ADD on the next beat -> out_err = 0.
REQ-041 SHALL cover rst_n pulsed low with 2 beats in flight -> out_valid = 0 immediately, and neither beat appears afterward.

Source files
------------

// File: rtl/cell_alu_pipe_pkg.sv
// CellProcessingPkg -- shared types and constants for the cell ALU pipeline.
//
// Contents:
//   opcodes_t        4-bit operation encoding (values 12-15 are illegal)
//   colorChannel_t   one color channel
//   pixel_t          CHANNEL_NUM channels, channel 0 in the low bits
//   cell_t           CELL_N*CELL_N pixels, pixel 0 in the low bits
//   PIXEL_DEPTH, CELL_DEPTH, CENTER_IDX  constants for the default geometry
//   pixel_depth(), cell_depth(), center_idx()  the same constants derived
//                    from arbitrary module parameters
//   illegal_op()     true for opcodes outside the defined set
//
// Optional feature macro used by the design: CELL_ALU_SATURATE_EN.
package CellProcessingPkg;

  localparam int CHANNEL_WIDTH = 8;
  localparam int CHANNEL_NUM   = 3;
  localparam int CELL_N        = 3;

  function automatic int pixel_depth(input int cw, input int cn);
    return cw * cn;
  endfunction

  function automatic int cell_depth(input int cw, input int cn, input int n);
    return cw * cn * n * n;
  endfunction

  function automatic int center_idx(input int n);
    return (n * n - 1) / 2;
  endfunction

  localparam int PIXEL_DEPTH = pixel_depth(CHANNEL_WIDTH, CHANNEL_NUM);
  localparam int CELL_DEPTH  = cell_depth(CHANNEL_WIDTH, CHANNEL_NUM, CELL_N);
  localparam int CENTER_IDX  = center_idx(CELL_N);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADDI  = 4'd1,
    OP_SUB   = 4'd2,
    OP_SUBI  = 4'd3,
    OP_MULT  = 4'd4,
    OP_MULTI = 4'd5,
    OP_DIV2  = 4'd6,
    OP_INV   = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_NOR   = 4'd10,
    OP_AVG   = 4'd11
  } opcodes_t;

  typedef logic [CHANNEL_WIDTH-1:0] colorChannel_t;
  typedef logic [PIXEL_DEPTH-1:0]   pixel_t;
  typedef logic [CELL_DEPTH-1:0]    cell_t;

  function automatic logic illegal_op(input logic [3:0] op);
    return op > OP_AVG;
  endfunction

endpackage

// File: rtl/cell_channel_alu.sv
// cell_channel_alu -- one color channel of the cell ALU (pure combinational).
//
// Ports:
//   opcode  in   4   operation (opcodes_t encoding)
//   a       in   W   center channel of cell A
//   b       in   W   center channel of cell B
//   imm     in   W   immediate operand
//   avg     in   W   precomputed cell average for this channel
//   res     out  W   result (0 for illegal opcodes)
//
// Macro CELL_ALU_SATURATE_EN: when defined, ADD/ADDI/MULT/MULTI clamp at
// all-ones and SUB/SUBI clamp at zero; otherwise they wrap modulo 2^W.
module cell_channel_alu
  import CellProcessingPkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] avg,
  output logic [W-1:0] res
);

`ifdef CELL_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // One extra bit holds the carry / borrow; products are full width so the
  // clamp can look at every overflow bit.
  logic [W:0]     sum_ab, sum_ai, dif_ab, dif_ai;
  logic [2*W-1:0] mul_ab, mul_ai;

  assign sum_ab = {1'b0, a} + {1'b0, b};
  assign sum_ai = {1'b0, a} + {1'b0, imm};
  assign dif_ab = {1'b0, a} - {1'b0, b};
  assign dif_ai = {1'b0, a} - {1'b0, imm};
  assign mul_ab = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign mul_ai = {{W{1'b0}}, a} * {{W{1'b0}}, imm};

  function automatic logic [W-1:0] fit_sum(input logic [W:0] s);
    return (SAT && s[W]) ? {W{1'b1}} : s[W-1:0];
  endfunction

  // Borrow out of the top bit means the true difference is negative.
  function automatic logic [W-1:0] fit_dif(input logic [W:0] d);
    return (SAT && d[W]) ? {W{1'b0}} : d[W-1:0];
  endfunction

  function automatic logic [W-1:0] fit_mul(input logic [2*W-1:0] p);
    return (SAT && (|p[2*W-1:W])) ? {W{1'b1}} : p[W-1:0];
  endfunction

  always_comb begin
    res = '0;
    case (opcode)
      OP_ADD:   res = fit_sum(sum_ab);
      OP_ADDI:  res = fit_sum(sum_ai);
      OP_SUB:   res = fit_dif(dif_ab);
      OP_SUBI:  res = fit_dif(dif_ai);
      OP_MULT:  res = fit_mul(mul_ab);
      OP_MULTI: res = fit_mul(mul_ai);
      OP_DIV2:  res = a >> 1;
      OP_INV:   res = ~a;
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_NOR:   res = ~(a | b);
      OP_AVG:   res = avg;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/cell_alu_pipe.sv
// cell_alu_pipe -- two-stage pixel-cell ALU with valid/ready flow control.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   input handshake
//   opcode  [3:0]    operation (opcodes_t; 12-15 flag out_err)
//   cell_a           CELL_N*CELL_N pixels, pixel 0 in the low bits
//   cell_b           only its center pixel is used
//   user_in          immediate operand
//   out_valid/ready  output handshake
//   out_pixel        result pixel, channel 0 in the low bits
//   out_err          result came from an illegal opcode
//
// Macro CELL_ALU_SATURATE_EN selects clamping instead of wrapping for the
// add/sub/mult families (inside cell_channel_alu).
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid and ready are both high. Valid, once raised, holds with stable data
// until taken. in_ready is a function of pipeline state and out_ready only,
// never of in_valid.
module cell_alu_pipe
  import CellProcessingPkg::*;
#(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CHANNEL_NUM   = 3,
  parameter int CELL_N        = 3
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [3:0]                                          opcode,
  input  logic [CHANNEL_WIDTH*CHANNEL_NUM*CELL_N*CELL_N-1:0]  cell_a,
  input  logic [CHANNEL_WIDTH*CHANNEL_NUM*CELL_N*CELL_N-1:0]  cell_b,
  input  logic [CHANNEL_WIDTH-1:0]                            user_in,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [CHANNEL_WIDTH*CHANNEL_NUM-1:0]                out_pixel,
  output logic                                                out_err
);

  localparam int PIX_W  = pixel_depth(CHANNEL_WIDTH, CHANNEL_NUM);
  localparam int CELL_W = cell_depth(CHANNEL_WIDTH, CHANNEL_NUM, CELL_N);
  localparam int CTR    = center_idx(CELL_N);
  localparam int NPIX   = CELL_N * CELL_N;
  localparam int ACC_W  = CHANNEL_WIDTH + $clog2(NPIX);

  // Stage 1 registers.
  logic                     s1_valid;
  logic [3:0]               s1_op;
  logic [CELL_W-1:0]        s1_cell;
  logic [PIX_W-1:0]         s1_b;
  logic [CHANNEL_WIDTH-1:0] s1_user;

  // Stage 2 registers drive the outputs directly.
  logic                     s2_valid;
  logic [PIX_W-1:0]         s2_pixel;
  logic                     s2_err;

  logic             s1_advance, s2_advance;
  logic [PIX_W-1:0] center_a;
  logic [PIX_W-1:0] alu_pixel;
  logic             s1_err;

  // Only the center of cell_b is captured; fold the rest away.
  logic cell_b_unused;
  assign cell_b_unused = ^cell_b;

  assign s2_advance = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_advance;
  assign in_ready   = !s1_valid || s1_advance;

  assign out_valid = s2_valid;
  assign out_pixel = s2_pixel;
  assign out_err   = s2_err;

  assign center_a = s1_cell[CTR*PIX_W +: PIX_W];
  assign s1_err   = illegal_op(s1_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_cell  <= '0;
      s1_b     <= '0;
      s1_user  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= opcode;
        s1_cell <= cell_a;
        s1_b    <= cell_b[CTR*PIX_W +: PIX_W];
        s1_user <= user_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_pixel <= '0;
      s2_err   <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pixel <= s1_err ? '0 : alu_pixel;
        s2_err   <= s1_err;
      end
    end
  end

  for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : g_chan
    logic [ACC_W-1:0]         acc;
    logic [CHANNEL_WIDTH-1:0] avg_val;

    // The accumulator is wide enough for NPIX full-scale values, and the
    // divide by the pixel count is a true floor division.
    always_comb begin
      acc = '0;
      for (int p = 0; p < NPIX; p++) begin
        acc = acc + ACC_W'(s1_cell[(p*CHANNEL_NUM+ch)*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
      end
      avg_val = CHANNEL_WIDTH'(acc / ACC_W'(NPIX));
    end

    cell_channel_alu #(.W(CHANNEL_WIDTH)) u_alu (
      .opcode (s1_op),
      .a      (center_a[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
      .b      (s1_b[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
      .imm    (s1_user),
      .avg    (avg_val),
      .res    (alu_pixel[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH])
    );
  end

endmodule

// File: tb/tb_cell_alu_pipe.sv
// tb_cell_alu_pipe -- self-checking bench for cell_alu_pipe (default geometry).
// Follows CELL_ALU_SATURATE_EN the same way the design does.
module tb_cell_alu_pipe;
  import CellProcessingPkg::*;

  localparam int W    = 8;
  localparam int CH   = 3;
  localparam int NPIX = 9;
  localparam int PW   = W * CH;
  localparam int CW   = PW * NPIX;
  localparam int CTR  = 4;
  localparam int MAXV = (1 << W) - 1;

`ifdef CELL_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    opcode = '0;
  logic [CW-1:0] cell_a = '0;
  logic [CW-1:0] cell_b = '0;
  logic [W-1:0]  user_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pixel;
  logic          out_err;

  always #5 clk = ~clk;

  cell_alu_pipe #(.CHANNEL_WIDTH(W), .CHANNEL_NUM(CH), .CELL_N(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .cell_a    (cell_a),
    .cell_b    (cell_b),
    .user_in   (user_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_err   (out_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entries are {err, pixel}.
  logic [PW:0] exp_q[$];
  logic [PW:0] got_q[$];

  // ---------------- reference model ----------------
  function automatic logic [PW:0] model(input logic [3:0] op, input logic [CW-1:0] ca,
                                        input logic [CW-1:0] cb, input logic [W-1:0] u);
    logic [PW-1:0] px;
    px = '0;
    if (op >= 4'd12) return {1'b1, {PW{1'b0}}};
    for (int c = 0; c < CH; c++) begin
      int a;
      int b;
      int imm;
      int r;
      int sum;
      a   = int'(ca[(CTR*CH+c)*W +: W]);
      b   = int'(cb[(CTR*CH+c)*W +: W]);
      imm = int'(u);
      sum = 0;
      for (int p = 0; p < NPIX; p++) sum += int'(ca[(p*CH+c)*W +: W]);
      case (op)
        4'd0:    r = a + b;
        4'd1:    r = a + imm;
        4'd2:    r = a - b;
        4'd3:    r = a - imm;
        4'd4:    r = a * b;
        4'd5:    r = a * imm;
        4'd6:    r = a / 2;
        4'd7:    r = MAXV - a;
        4'd8:    r = a & b;
        4'd9:    r = a | b;
        4'd10:   r = MAXV - (a | b);
        default: r = sum / NPIX;
      endcase
      if (SAT) begin
        if (r > MAXV) r = MAXV;
        if (r < 0) r = 0;
      end
      r = r & MAXV;
      px[c*W +: W] = W'(r);
    end
    return {1'b0, px};
  endfunction

  function automatic logic [CW-1:0] rand_cell();
    logic [CW-1:0] c;
    for (int i = 0; i < CW / 8; i++) c[i*8 +: 8] = 8'($urandom_range(0, 255));
    return c;
  endfunction

  // ---------------- monitor: record accepted inputs and taken outputs ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(opcode, cell_a, cell_b, user_in));
      if (out_valid && out_ready) got_q.push_back({out_err, out_pixel});
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic drive_random();
    opcode   = 4'($urandom_range(0, 15));
    cell_a   = rand_cell();
    cell_b   = rand_cell();
    user_in  = W'($urandom_range(0, MAXV));
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] op, input logic [CW-1:0] ca,
                      input logic [CW-1:0] cb, input logic [W-1:0] u);
    bit acc;
    acc      = 1'b0;
    opcode   = op;
    cell_a   = ca;
    cell_b   = cb;
    user_in  = u;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never rose within 200 cycles, required 1");
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && got_q.size() < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [CW-1:0] ca;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_pixel !== '0) begin n_fail++; $display("FAIL rst_out_pixel: got %h want 0", out_pixel); end
    n_tests++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err: got %b want 0", out_err); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Offer a beat immediately: the first edge after release must take it.
    ca       = rand_cell();
    opcode   = OP_ADD;
    cell_a   = ca;
    cell_b   = rand_cell();
    user_in  = 8'h11;
    in_valid = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_edge_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_tests++; if (exp_q.size() !== 1) begin n_fail++; $display("FAIL first_edge_accept: got %0d beats want 1", exp_q.size()); end
    drain();
    n_tests++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL first_edge_result: got %0d beats, want 1 beat of %h", got_q.size(), exp_q[0]);
    end
    clear_sb();
  endtask

  task automatic test_vectors();
    logic [3:0]    v_op[4];
    logic [CW-1:0] v_a[4];
    logic [CW-1:0] v_b[4];
    logic [W-1:0]  v_u[4];
    logic [PW-1:0] v_exp[4];
    logic [PW-1:0] v_mask[4];
    // ADDI
    v_op[0] = OP_ADDI; v_a[0] = rand_cell(); v_a[0][CTR*PW +: PW] = 24'h8010F0;
    v_b[0] = rand_cell(); v_u[0] = 8'h20; v_mask[0] = '1;
    v_exp[0] = SAT ? 24'hA030FF : 24'hA03010;
    // SUB
    v_op[1] = OP_SUB; v_a[1] = rand_cell(); v_a[1][CTR*PW +: PW] = 24'h005005;
    v_b[1] = rand_cell(); v_b[1][CTR*PW +: PW] = 24'h011010; v_u[1] = 8'h00; v_mask[1] = '1;
    v_exp[1] = SAT ? 24'h004000 : 24'hFF40F5;
    // AVG of all-ones cell
    v_op[2] = OP_AVG; v_a[2] = '1; v_b[2] = rand_cell(); v_u[2] = 8'h00; v_mask[2] = '1;
    v_exp[2] = 24'hFFFFFF;
    // AVG with channel 0 = pixel index
    v_op[3] = OP_AVG; v_a[3] = rand_cell();
    for (int p = 0; p < NPIX; p++) v_a[3][p*PW +: W] = W'(p);
    v_b[3] = rand_cell(); v_u[3] = 8'h00; v_mask[3] = 24'h0000FF; v_exp[3] = 24'h000004;
    for (int i = 0; i < 4; i++) begin
      clear_sb();
      send(v_op[i], v_a[i], v_b[i], v_u[i]);
      drain();
      n_tests++;
      if (got_q.size() !== 1) begin
        n_fail++;
        $display("FAIL vector%0d_count: got %0d beats want 1", i, got_q.size());
      end else begin
        if ((got_q[0][PW-1:0] & v_mask[i]) !== v_exp[i] || got_q[0][PW] !== 1'b0) begin
          n_fail++;
          $display("FAIL vector%0d_value: got err=%b pix=%h want err=0 pix=%h (mask %h)",
                   i, got_q[0][PW], got_q[0][PW-1:0], v_exp[i], v_mask[i]);
        end
        n_tests++;
        if (got_q[0] !== exp_q[0]) begin
          n_fail++;
          $display("FAIL vector%0d_model: got %h want %h", i, got_q[0], exp_q[0]);
        end
      end
    end
    clear_sb();
  endtask

  task automatic test_back_to_back();
    logic [3:0]    ops[3];
    logic [CW-1:0] a[3];
    logic [CW-1:0] b[3];
    logic [W-1:0]  u[3];
    logic [PW:0]   e[3];
    ops[0] = OP_ADD; ops[1] = OP_INV; ops[2] = OP_DIV2;
    for (int i = 0; i < 3; i++) begin
      a[i] = rand_cell(); b[i] = rand_cell(); u[i] = W'($urandom_range(0, MAXV));
      e[i] = model(ops[i], a[i], b[i], u[i]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        opcode = ops[i]; cell_a = a[i]; cell_b = b[i]; user_in = u[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== (i >= 2 && i <= 4)) begin
        n_fail++;
        $display("FAIL b2b_valid_cycle%0d: got %b want %b", i, out_valid, (i >= 2 && i <= 4));
      end else if (i >= 2 && i <= 4) begin
        n_tests++;
        if ({out_err, out_pixel} !== e[i-2]) begin
          n_fail++;
          $display("FAIL b2b_result_cycle%0d: got %h want %h", i, {out_err, out_pixel}, e[i-2]);
        end
      end
      @(posedge clk);
      #1;
    end
    drain();
    clear_sb();
  endtask

  task automatic test_stall();
    bit            acc;
    logic [PW-1:0] hold;
    hold = '0;
    clear_sb();
    out_ready = 1'b0;
    drive_random();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acc = in_ready;
      n_tests++;
      if (in_ready !== (k < 2)) begin
        n_fail++;
        $display("FAIL stall_in_ready_cycle%0d: got %b want %b", k, in_ready, (k < 2));
      end
      if (k >= 2) begin
        n_tests++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_out_valid_cycle%0d: got %b want 1", k, out_valid);
        end
        if (k == 2) hold = out_pixel;
        else begin
          n_tests++;
          if (out_pixel !== hold) begin
            n_fail++;
            $display("FAIL stall_hold_cycle%0d: got %h want %h", k, out_pixel, hold);
          end
        end
      end
      @(posedge clk);
      #1;
      if (acc) drive_random();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) drive_random();
    end
    drain();
    n_tests++;
    if (got_q.size() !== exp_q.size() || got_q.size() == 0) begin
      n_fail++;
      $display("FAIL stall_count: got %0d beats want %0d", got_q.size(), exp_q.size());
    end else begin
      n_tests++;
      if (got_q[0][PW-1:0] !== hold) begin
        n_fail++;
        $display("FAIL stall_first_beat: got %h want held %h", got_q[0][PW-1:0], hold);
      end
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL stall_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    clear_sb();
  endtask

  task automatic test_illegal();
    clear_sb();
    out_ready = 1'b1;
    send(4'd14, rand_cell(), rand_cell(), 8'h5A);
    send(OP_ADD, rand_cell(), rand_cell(), 8'h00);
    drain();
    n_tests++;
    if (got_q.size() !== 2) begin
      n_fail++;
      $display("FAIL illegal_count: got %0d beats want 2", got_q.size());
    end else begin
      n_tests++;
      if (got_q[0] !== {1'b1, {PW{1'b0}}}) begin
        n_fail++;
        $display("FAIL illegal_op14: got err=%b pix=%h want err=1 pix=0", got_q[0][PW], got_q[0][PW-1:0]);
      end
      n_tests++;
      if (got_q[1][PW] !== 1'b0 || got_q[1] !== exp_q[1]) begin
        n_fail++;
        $display("FAIL illegal_then_add: got %h want %h", got_q[1], exp_q[1]);
      end
    end
    clear_sb();
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    clear_sb();
    fork
      begin
        for (int i = 0; i < 300; i++)
          send(4'($urandom_range(0, 15)), rand_cell(), rand_cell(), W'($urandom_range(0, MAXV)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d beats want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    clear_sb();
  endtask

  task automatic test_reset_in_flight();
    clear_sb();
    out_ready = 1'b0;
    send(OP_ADD, rand_cell(), rand_cell(), 8'h00);
    send(OP_INV, rand_cell(), rand_cell(), 8'h00);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flight_before_reset: got out_valid=%b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_pixel !== '0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flight_reset_now: got valid=%b pix=%h err=%b ready=%b want 0/0/0/1",
               out_valid, out_pixel, out_err, in_ready);
    end
    clear_sb();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (got_q.size() !== 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flight_no_ghosts: got %0d beats, out_valid=%b, want 0 and 0", got_q.size(), out_valid);
    end
    clear_sb();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_random();
    test_reset_in_flight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
